calc_history: RTL
=================

CALC_HISTORY -- requirements
Module: calc_history

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: accumulator/switch/LED width, legal range 4..32.
REQ-002 SHALL have parameter DEPTH, default 8: undo-history entries, a power of two, at least 2.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 4: stable cycles required before a button is accepted, at least 1.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 btnc, btnl, btnr  input  1 each  raw op-select buttons.
REQ-007 btnd  input  1  raw execute button.
REQ-008 btnu  input  1  raw clear button; performs undo when btnl is held.
REQ-009 sw  input  DATA_WIDTH  operand 2, two's complement.
REQ-010 led  output  DATA_WIDTH  accumulator value.
REQ-011 hist_count  output  $clog2(DEPTH+1)  number of valid history entries.
REQ-012 lost  output  1  sticky flag: a history entry was discarded.
REQ-013 err  output  1  one-cycle pulse: undo requested with empty history.
REQ-014 acc_zero  output  1  high when the accumulator equals 0.

Function
REQ-015 Each raw button SHALL pass a 2-FF synchroniser, then a debouncer whose level changes only after DEBOUNCE_CYCLES consecutive equal synchronised samples.
REQ-016 Each debounced rising edge SHALL produce exactly one single-cycle pulse, however long the button is held.
REQ-017 Op-select SHALL be the debounced levels {btnl,btnc,btnr} sampled in the btnd pulse cycle: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 LT, 110 LSL, 111 ASR.
REQ-018 ALU operands SHALL be 32 bits: op1 = sign-extended accumulator, op2 = sign-extended sw.
REQ-019 The result SHALL be truncated to DATA_WIDTH bits.
REQ-020 Execute (btnd pulse): in the next cycle, the old accumulator is pushed to history and the accumulator takes the result.
REQ-021 History SHALL be a circular LIFO. A push when hist_count==DEPTH overwrites the oldest entry, leaves hist_count at DEPTH, and sets lost.
REQ-022 Undo (btnu pulse with btnl debounced high), when hist_count>0: in the next cycle, the accumulator takes the top entry and hist_count decrements.
REQ-023 Undo when hist_count==0: accumulator and history are unchanged, and err pulses for one cycle.
REQ-024 Clear (btnu pulse with btnl low): in the next cycle, the accumulator becomes 0, hist_count becomes 0 and lost is cleared.
REQ-025 If btnu and btnd pulses occur in the same cycle, the btnu command SHALL win and the execute is dropped.
REQ-026 Command decode SHALL be a registered FSM with states IDLE, EXEC, UNDO, CLEAR. Each command state lasts exactly one cycle and then returns to IDLE. Pulses arriving outside IDLE are dropped.
REQ-027 Latency: a raw press stable from cycle t updates led at cycle t+2+DEBOUNCE_CYCLES+2.
REQ-028 led and acc_zero SHALL be driven directly from registers or register-only logic, with no path from sw.

Reset
REQ-029 When rst_n is low, these SHALL be forced immediately, regardless of clock: led=0, hist_count=0, lost=0, err=0, FSM=IDLE, all synchroniser/debouncer state=0, one-shots idle.
REQ-030 Reset asserted mid-command SHALL abort the command with no partial update after release.
REQ-031 History RAM contents need not be reset; hist_count=0 makes them invalid.

Structure
REQ-032 Package calc_defs SHALL hold: calc_state_t (IDLE/EXEC/UNDO/CLEAR), the 3-bit op-select to alu_op_t mapping function, and ALU_WIDTH=32. alu_op_t remains in alu_defs.
REQ-033 Sub-module btn_debounce (sync + debounce + one-shot, parameter DEBOUNCE_CYCLES) SHALL be instantiated once per button.
REQ-034 The existing alu SHALL be instantiated with BUS_WIDTH=ALU_WIDTH.

Verification (DATA_WIDTH=16, DEPTH=4, DEBOUNCE_CYCLES=4)
REQ-035 Reset: pulse rst_n low mid-EXEC -> led=0x0000, hist_count=0, lost=0 without a clock edge.
REQ-036 Execute and SUB: sw=0x0005, btnd -> led=0x0005, hist_count=1. Then sw=0xFFFF with btnr held, btnd -> led=0x0006, hist_count=2.
REQ-037 Debounce: btnd high for 3 cycles -> no change. btnd held 100 cycles -> exactly one update.
REQ-038 Overflow: 5 executes -> hist_count=4, lost=1. Then 4 undos restore prior values in reverse. A 5th undo -> err pulses once, led unchanged.
REQ-039 Simultaneous: btnu and btnd rising in the same cycle -> led=0x0000, hist_count=0, no execute.
REQ-040 Signed ops:
- acc=0x8000, sw=0x0001, op 111 -> led=0xC000.
- acc=0xFFFF, sw=0x0001, op 101 -> led=0x0001, acc_zero=0.

Source files
------------

// File: rtl/alu_defs.sv
// rtl/alu_defs.sv - ALU operation encoding shared by the ALU and its users.
package alu_defs;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_LT  = 3'b101,
        ALU_LSL = 3'b110,
        ALU_ASR = 3'b111
    } alu_op_t;

endpackage

// File: rtl/calc_defs.sv
// rtl/calc_defs.sv - calculator command states, ALU width and op-select decode.
package calc_defs;
    import alu_defs::*;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        UNDO  = 2'd2,
        CLEAR = 2'd3
    } calc_state_t;

    // Button order is {btnl, btnc, btnr}.
    function automatic alu_op_t op_from_sel(input logic [2:0] sel);
        alu_op_t op;
        case (sel)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SUB;
            3'b010:  op = ALU_AND;
            3'b011:  op = ALU_OR;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_LT;
            3'b110:  op = ALU_LSL;
            default: op = ALU_ASR;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational two's-complement ALU.
module alu
    import alu_defs::*;
#(
    parameter int BUS_WIDTH = 32
) (
    input  alu_op_t              op,
    input  logic [BUS_WIDTH-1:0] a,
    input  logic [BUS_WIDTH-1:0] b,
    output logic [BUS_WIDTH-1:0] y
);

    localparam int SHW = $clog2(BUS_WIDTH);

    logic [SHW-1:0] shamt;
    assign shamt = b[SHW-1:0];

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_LT:  y = {{(BUS_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_LSL: y = a << shamt;
            ALU_ASR: y = $signed(a) >>> shamt;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchroniser, counting debouncer and rising-edge one-shot.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          prev_q, prev_d;

    // The level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        cnt_d   = '0;
        level_d = level_q;
        prev_d  = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            prev_q  <= prev_d;
        end
    end

    assign level = level_q;
    assign pulse = level_q & ~prev_q;

endmodule

// File: rtl/calc_history.sv
// rtl/calc_history.sv - button-driven accumulator calculator with circular undo history.
module calc_history
    import alu_defs::*;
    import calc_defs::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int DEPTH           = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         btnc,
    input  logic                         btnl,
    input  logic                         btnr,
    input  logic                         btnd,
    input  logic                         btnu,
    input  logic [DATA_WIDTH-1:0]        sw,
    output logic [DATA_WIDTH-1:0]        led,
    output logic [$clog2(DEPTH+1)-1:0]   hist_count,
    output logic                         lost,
    output logic                         err,
    output logic                         acc_zero
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic l_lvl, c_lvl, r_lvl, l_pls, c_pls, r_pls;
    logic d_pls, u_pls, d_lvl_unused, u_lvl_unused;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (
        .clk(clk), .rst_n(rst_n), .btn_raw(btnl), .level(l_lvl), .pulse(l_pls));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_c (
        .clk(clk), .rst_n(rst_n), .btn_raw(btnc), .level(c_lvl), .pulse(c_pls));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (
        .clk(clk), .rst_n(rst_n), .btn_raw(btnr), .level(r_lvl), .pulse(r_pls));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_d (
        .clk(clk), .rst_n(rst_n), .btn_raw(btnd), .level(d_lvl_unused), .pulse(d_pls));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_u (
        .clk(clk), .rst_n(rst_n), .btn_raw(btnu), .level(u_lvl_unused), .pulse(u_pls));

    // Op-select buttons are read as levels only.
    logic unused_sel_pulses;
    assign unused_sel_pulses = l_pls ^ c_pls ^ r_pls;

    calc_state_t           state_q, state_d;
    logic [2:0]            op_sel_q, op_sel_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]         count_q, count_d;
    logic [AW-1:0]         top_q, top_d;
    logic                  lost_q, lost_d;
    logic                  err_q, err_d;
    logic                  hist_we;

    logic [DATA_WIDTH-1:0] hist_mem [DEPTH];
    logic [AW-1:0]         top_prev;
    assign top_prev = top_q - AW'(1);

    logic [ALU_WIDTH-1:0] alu_a, alu_b, alu_y;
    logic                 unused_alu_bits;
    assign alu_a = ALU_WIDTH'($signed(acc_q));
    assign alu_b = ALU_WIDTH'($signed(sw));
    assign unused_alu_bits = ^alu_y;

    alu #(.BUS_WIDTH(ALU_WIDTH)) u_alu (
        .op (op_from_sel(op_sel_q)),
        .a  (alu_a),
        .b  (alu_b),
        .y  (alu_y)
    );

    // A btnu pulse outranks a coincident btnd pulse; pulses outside IDLE are ignored.
    always_comb begin
        state_d  = IDLE;
        op_sel_d = op_sel_q;
        acc_d    = acc_q;
        count_d  = count_q;
        top_d    = top_q;
        lost_d   = lost_q;
        err_d    = 1'b0;
        hist_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (u_pls) begin
                    state_d = l_lvl ? UNDO : CLEAR;
                end else if (d_pls) begin
                    state_d  = EXEC;
                    op_sel_d = {l_lvl, c_lvl, r_lvl};
                end
            end
            EXEC: begin
                hist_we = 1'b1;
                acc_d   = alu_y[DATA_WIDTH-1:0];
                top_d   = top_q + AW'(1);
                if (count_q == FULL) begin
                    lost_d = 1'b1;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            UNDO: begin
                if (count_q != '0) begin
                    acc_d   = hist_mem[top_prev];
                    top_d   = top_prev;
                    count_d = count_q - CW'(1);
                end else begin
                    err_d = 1'b1;
                end
            end
            CLEAR: begin
                acc_d   = '0;
                count_d = '0;
                lost_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_sel_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            top_q    <= '0;
            lost_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_sel_q <= op_sel_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            top_q    <= top_d;
            lost_q   <= lost_d;
            err_q    <= err_d;
        end
    end

    // History storage is left unreset; count_q alone marks which entries are valid.
    always_ff @(posedge clk) begin
        if (hist_we) begin
            hist_mem[top_q] <= acc_q;
        end
    end

    assign led        = acc_q;
    assign hist_count = count_q;
    assign lost       = lost_q;
    assign err        = err_q;
    assign acc_zero   = (acc_q == '0);

endmodule
